// File: rtl/simd_mem_pkg.sv
// Shared types for the SIMD data-RAM arbiter.
// State encoding and pointer-width helper.
package simd_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simd_mem_arbiter_rr_pick.sv
// Round-robin picker: one-hot winner is the first
// pending index at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  logic [N-1:0] rot;
  logic [N-1:0] oh;

  // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
  assign rot = N'({pending, pending} >> ptr);
  assign oh  = rot & (~rot + N'(1));
  assign win = N'(({oh, oh} << ptr) >> N);

endmodule

// File: rtl/simd_mem_arbiter.sv
// Shared single-port data-RAM arbiter for SIMD cores
// with round-robin grant and same-address read merge.
module simd_mem_arbiter
  import simd_mem_pkg::*;
#(
  parameter int NCORES   = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int BCAST_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORES-1:0]        req_rd,
  input  logic [NCORES-1:0]        req_wr,
  input  logic [NCORES*ADDR_W-1:0] req_addr,
  input  logic [NCORES*DATA_W-1:0] req_wdata,
  input  logic                     ext_hold,
  input  logic [DATA_W-1:0]        ram_q,
  output logic [NCORES-1:0]        ack,
  output logic [NCORES*DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  output logic                     ram_wren,
  output logic                     busy
);

  localparam int PW = idx_w(NCORES);

  state_t              state, state_n;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       hi;
  logic [NCORES-1:0]   g, g_n;
  logic [NCORES-1:0]   pending, win, bmask;
  logic [2:0]          cnt;
  logic [ADDR_W-1:0]   addr_w;
  logic [DATA_W-1:0]   wdata_w;
  logic                wr_w;

  assign pending = req_rd | req_wr;

  rr_pick #(
    .N  (NCORES),
    .PW (PW)
  ) u_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .win     (win)
  );

  always_comb begin
    addr_w  = '0;
    wdata_w = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (win[i]) begin
        addr_w  = req_addr[i*ADDR_W +: ADDR_W];
        wdata_w = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_w = |(req_wr & win);

  always_comb begin
    bmask = '0;
    for (int i = 0; i < NCORES; i++) begin
      bmask[i] = req_rd[i] & ~req_wr[i] &
        (req_addr[i*ADDR_W +: ADDR_W] == addr_w);
    end
  end

  // writes are never merged
  assign g_n = (BCAST_EN != 0 && !wr_w) ? bmask : win;

  always_comb begin
    hi = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (g[i]) hi = PW'(i);
    end
  end

  assign ack  = (state == S_ACK) ? g : '0;
  assign busy = (state != S_IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (!ext_hold && |pending) state_n = S_ISSUE;
      S_ISSUE:
        state_n = ram_wren ? S_ACK : S_WAIT;
      S_WAIT:
        if (cnt == '0) state_n = S_ACK;
      S_ACK:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      g        <= '0;
      cnt      <= '0;
      rdata    <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_wren <= 1'b0;
    end else begin
      state    <= state_n;
      ram_wren <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (state_n == S_ISSUE) begin
            g        <= g_n;
            ram_addr <= addr_w;
            ram_din  <= wdata_w;
            ram_wren <= wr_w;
          end
        end
        S_ISSUE:
          cnt <= 3'(RD_LAT - 1);
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == '0) begin
            for (int i = 0; i < NCORES; i++) begin
              if (g[i]) rdata[i*DATA_W +: DATA_W] <= ram_q;
            end
          end
        end
        S_ACK:
          rr_ptr <= (hi == PW'(NCORES - 1)) ? '0 : hi + PW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// Bench for simd_mem_arbiter: three instances (default,
// no broadcast, RD_LAT=3), each with its own RAM model.
module tb_simd_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        ext_hold = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  rq_rd [3];
  logic [3:0]  rq_wr [3];
  logic [3:0]  ack_o [3];
  logic [31:0] rdata_o [3];
  logic [7:0]  addr_o [3];
  logic [7:0]  din_o [3];
  logic [7:0]  q [3];
  logic        wren_o [3];
  logic        busy_o [3];

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 8'h5A;
    if (a == 8'h44) return 8'h99;
    return a ^ 8'hA5;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int L = (k == 2) ? 3 : 1;
    logic [7:0] mem [256];
    logic [7:0] pipe [L];

    always @(posedge clk) begin
      if (load) begin
        for (int a = 0; a < 256; a++) mem[a] <= init_val(8'(a));
      end else if (wren_o[k]) begin
        mem[addr_o[k]] <= din_o[k];
      end
      pipe[0] <= mem[addr_o[k]];
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end
    assign q[k] = pipe[L-1];

    simd_mem_arbiter #(
      .NCORES   (4),
      .ADDR_W   (8),
      .DATA_W   (8),
      .RD_LAT   (L),
      .BCAST_EN ((k == 1) ? 0 : 1)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_rd    (rq_rd[k]),
      .req_wr    (rq_wr[k]),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ext_hold  (ext_hold),
      .ram_q     (q[k]),
      .ack       (ack_o[k]),
      .rdata     (rdata_o[k]),
      .ram_addr  (addr_o[k]),
      .ram_din   (din_o[k]),
      .ram_wren  (wren_o[k]),
      .busy      (busy_o[k])
    );
  end

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] din;
  } iss_t;

  typedef struct {
    int         cyc;
    logic [3:0] ack;
    logic [3:0] rdm;
    logic [7:0] d;
  } ack_t;

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          n;
    logic [15:0] acks;
    logic [31:0] data;
  } vec_t;

  iss_t iq [3][$];
  ack_t aq [3][$];
  vec_t vt [7];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic bad(input string nm, input int k);
    ncmp++;
    nfail++;
    $display("FAIL %s @%0d: inst %0d got event want none", nm, cyc, k);
  endtask

  task automatic tick();
    iss_t ie;
    ack_t ae;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      while (iq[k].size() > 0 && iq[k][0].cyc < cyc) begin
        ie = iq[k].pop_front();
        bad("missing_issue", k);
      end
      if (iq[k].size() > 0 && iq[k][0].cyc == cyc) begin
        ie = iq[k].pop_front();
        chk("issue_addr", 32'(addr_o[k]), 32'(ie.addr));
        chk("issue_wren", 32'(wren_o[k]), 32'(ie.wr));
        chk("issue_busy", 32'(busy_o[k]), 32'd1);
        if (ie.wr) chk("issue_din", 32'(din_o[k]), 32'(ie.din));
      end else if (wren_o[k]) begin
        bad("stray_wren", k);
      end
      while (aq[k].size() > 0 && aq[k][0].cyc < cyc) begin
        ae = aq[k].pop_front();
        bad("missing_ack", k);
      end
      if (ack_o[k] != 4'b0) begin
        if (aq[k].size() == 0) begin
          bad("stray_ack", k);
        end else begin
          ae = aq[k].pop_front();
          chk("ack_vec", 32'(ack_o[k]), 32'(ae.ack));
          chk("ack_cyc", cyc, ae.cyc);
          for (int i = 0; i < 4; i++)
            if (ae.rdm[i])
              chk("rdata", 32'(rdata_o[k][i*8 +: 8]), 32'(ae.d));
        end
      end
      rq_rd[k] = rq_rd[k] & ~ack_o[k];
      rq_wr[k] = rq_wr[k] & ~ack_o[k];
    end
  endtask

  task automatic push(input int k, input int t0, input logic [3:0] a,
                      input logic wrf, input logic [7:0] ad,
                      input logic [7:0] dn, input logic [7:0] d,
                      output int tn);
    int ta;
    ta = t0 + (wrf ? 2 : 2 + lat_of(k));
    iq[k].push_back('{cyc: t0 + 1, addr: ad, wr: wrf, din: dn});
    aq[k].push_back('{cyc: ta, ack: a, rdm: wrf ? 4'b0 : a, d: d});
    tn = ta + 1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((iq[0].size() + iq[1].size() + iq[2].size() +
            aq[0].size() + aq[1].size() + aq[2].size()) > 0 &&
           guard < 80) begin
      tick();
      guard++;
    end
    if (guard >= 80) begin
      bad("timeout", 0);
      for (int k = 0; k < 3; k++) begin
        iq[k].delete();
        aq[k].delete();
      end
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    ext_hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rq_rd[k] = 4'b0;
      rq_wr[k] = 4'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ack", 32'(ack_o[k]), 32'd0);
      chk("rst_busy", 32'(busy_o[k]), 32'd0);
      chk("rst_wren", 32'(wren_o[k]), 32'd0);
    end
    chk("rst_rdata", rdata_o[0], 32'd0);
    chk("rst_addr", 32'(addr_o[0]), 32'd0);
    chk("rst_din", 32'(din_o[0]), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  task automatic set_vec(input int i, input logic [3:0] rd,
                         input logic [3:0] wr, input logic [31:0] ad,
                         input logic [31:0] wd, input int n,
                         input logic [15:0] ac, input logic [31:0] da);
    vt[i] = '{rd: rd, wr: wr, addr: ad, wdata: wd, n: n,
              acks: ac, data: da};
  endtask

  initial begin
    int t;
    int idx;
    logic [3:0] a;
    logic wrf;
    vec_t v;

    for (int k = 0; k < 3; k++) begin
      rq_rd[k] = 4'b0;
      rq_wr[k] = 4'b0;
    end
    set_vec(0, 4'b0100, 4'b0000, 32'h0010_0000, 32'h0,
            1, 16'h0004, 32'h0000_005A);
    set_vec(1, 4'b0000, 4'b0010, 32'h0000_2000, 32'h0000_3300,
            1, 16'h0002, 32'h0);
    set_vec(2, 4'b0010, 4'b0000, 32'h0000_2000, 32'h0,
            1, 16'h0002, 32'h0000_0033);
    set_vec(3, 4'b1111, 4'b0000, 32'h0403_0201, 32'h0,
            4, 16'h8421, 32'hA1A6_A7A4);
    set_vec(4, 4'b1111, 4'b0000, 32'h4444_4544, 32'h0,
            2, 16'h002D, 32'h0000_E099);
    set_vec(5, 4'b1000, 4'b0001, 32'h4400_0044, 32'h0000_0077,
            2, 16'h0081, 32'h0000_7700);
    set_vec(6, 4'b0101, 4'b0001, 32'h0050_0050, 32'h0000_0066,
            2, 16'h0041, 32'h0000_6600);

    load = 1'b1;
    tick();
    load = 1'b0;

    for (int vi = 0; vi < 7; vi++) begin
      v = vt[vi];
      do_reset();
      rq_rd[0]  = v.rd;
      rq_wr[0]  = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      t = cyc;
      for (int n = 0; n < v.n; n++) begin
        a = v.acks[n*4 +: 4];
        idx = 0;
        for (int i = 3; i >= 0; i--) if (a[i]) idx = i;
        wrf = v.wr[idx];
        push(0, t, a, wrf, v.addr[idx*8 +: 8], v.wdata[idx*8 +: 8],
             v.data[n*8 +: 8], t);
      end
      drain();
    end

    // ext_hold freezes grants while idle
    do_reset();
    ext_hold = 1'b1;
    rq_rd[0] = 4'b0001;
    req_addr = 32'h0000_0010;
    repeat (10) begin
      tick();
      chk("hold_busy", 32'(busy_o[0]), 32'd0);
      chk("hold_addr", 32'(addr_o[0]), 32'd0);
    end
    ext_hold = 1'b0;
    push(0, cyc, 4'b0001, 1'b0, 8'h10, 8'h00, 8'h5A, t);
    drain();

    // reset while waiting on RAM data aborts the read
    do_reset();
    rq_rd[0] = 4'b0100;
    req_addr = 32'h0010_0000;
    iq[0].push_back('{cyc: cyc + 1, addr: 8'h10, wr: 1'b0, din: 8'h00});
    tick();
    tick();
    chk("wait_busy", 32'(busy_o[0]), 32'd1);
    rst = 1'b1;
    rq_rd[0] = 4'b0;
    tick();
    chk("abort_ack", 32'(ack_o[0]), 32'd0);
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    chk("abort_addr", 32'(addr_o[0]), 32'd0);
    chk("abort_rdata", rdata_o[0], 32'd0);
    rst = 1'b0;
    repeat (6) tick();

    // no merging when broadcast is disabled
    do_reset();
    rq_rd[1] = 4'b1111;
    req_addr = 32'h4444_4544;
    t = cyc;
    push(1, t, 4'b0001, 1'b0, 8'h44, 8'h00, 8'h99, t);
    push(1, t, 4'b0010, 1'b0, 8'h45, 8'h00, 8'hE0, t);
    push(1, t, 4'b0100, 1'b0, 8'h44, 8'h00, 8'h99, t);
    push(1, t, 4'b1000, 1'b0, 8'h44, 8'h00, 8'h99, t);
    drain();

    // longer RAM latency
    do_reset();
    rq_rd[2] = 4'b0100;
    req_addr = 32'h0010_0000;
    push(2, cyc, 4'b0100, 1'b0, 8'h10, 8'h00, 8'h5A, t);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/simd_mem_arbiter.md
Name: simd_mem_arbiter

Overview:
- Parametrised arbiter that gives NCORES SIMD cores shared access to one single-port data RAM.
- Each core has its own read/write request, address and write data; a single RAM port is time-multiplexed between them.
- Adds features the first-generation arbiter lacks:
  - fair round-robin grant;
  - configurable data/address width;
  - a read-broadcast mode, where one RAM read serves every core requesting the same address;
  - an explicit per-core ack handshake with registered read data.
- Sits between the core array and the data RAM. An external DMA/loader can freeze new grants through ext_hold.

Parameters:
NCORES, 4, number of requesting cores (2..16)
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
RD_LAT, 1, RAM read latency in cycles from address presented to ram_q valid (1..4)
BCAST_EN, 1, 1 enables merging identical-address reads into one access

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_rd  in  NCORES  per-core read request, held until ack
req_wr  in  NCORES  per-core write request, held until ack; wins over req_rd on the same core
req_addr  in  NCORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NCORES*DATA_W  per-core write data, same packing
ext_hold  in  1  when high in IDLE, no new grant is issued
ram_q  in  DATA_W  RAM read data
ack  out  NCORES  one-cycle completion pulse per served core
rdata  out  NCORES*DATA_W  per-core registered read data, valid from the ack cycle, held until that core's next read ack
ram_addr  out  ADDR_W  registered RAM address
ram_din  out  DATA_W  registered RAM write data
ram_wren  out  1  RAM write enable, high exactly one cycle per write
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: the following are all cleared to 0:
  - state = IDLE, rr_ptr = 0;
  - ack, rdata, ram_addr, ram_din, ram_wren, busy.
  - Reset mid-transaction aborts it: no ack is issued and ram_wren drops in the same edge.
- Request: pending[i] = req_rd[i] | req_wr[i].
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE (cycle T):
  - If ext_hold=1 or pending==0, stay in IDLE.
  - Otherwise select winner w = first pending index at or after rr_ptr, wrapping modulo NCORES.
  - Broadcast set:
    - Applies only if BCAST_EN=1 and req_wr[w]=0.
    - It is every i with req_rd[i]=1, req_wr[i]=0 and req_addr[i]==req_addr[w].
    - Otherwise the set is {w}.
    - Writes are never merged.
  - Register the grant vector g, ram_addr=req_addr[w] and ram_din=req_wdata[w]; ram_wren=req_wr[w] (this registered value drives the pin in ISSUE, T+1). Go to ISSUE.
- ISSUE (T+1):
  - RAM sees the address.
  - Write: ram_wren=1 this cycle only, next state ACK.
  - Read: ram_wren=0, next state WAIT, wait counter loaded with RD_LAT-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture ram_q into rdata[i] for every i in g, then go to ACK.
  - ram_q is sampled on the edge ending cycle T+1+RD_LAT.
- ACK:
  - ack = g for exactly one cycle.
  - Read ack at T+2+RD_LAT; write ack at T+2.
  - rr_ptr = (highest index in g)+1 mod NCORES.
  - Next state IDLE.
  - A core sees req high in ACK and must drop it next cycle; IDLE re-evaluates one cycle after ACK.
- Requests are sampled only in IDLE; changes during ISSUE/WAIT/ACK are ignored.
- A core that drops its request mid-transaction still receives its ack.
- ext_hold is ignored outside IDLE; an in-flight transaction always completes.
- ram_addr and ram_din hold their values after a transaction until the next grant.
- Throughput: one transaction per RD_LAT+3 cycles for reads, 3 cycles for writes.

Decomposition:
- Shared package simd_mem_pkg holds:
  - state encoding localparams S_IDLE, S_ISSUE, S_WAIT, S_ACK;
  - a clog2-based index-width constant for the NCORES pointer.
- One sub-module, rr_pick: a combinational round-robin priority picker with inputs pending[NCORES] and ptr, and output one-hot winner.
- Address-compare and broadcast-mask logic stays in the top level.

Test Plan (NCORES=4, ADDR_W=8, DATA_W=8, RAM model with RD_LAT=1 unless stated):
- Single read: core2 reads addr 0x10 (RAM holds 0x5A) -> ram_addr=0x10 at T+1, ack=4'b0100 at T+3, rdata[2]=0x5A, ram_wren never high.
- Single write then read: core1 writes 0x33 to 0x20 -> ram_wren=1 only at T+1 with ram_din=0x33, ack=4'b0010 at T+2; a following core1 read of 0x20 returns 0x33.
- Round-robin: all 4 cores hold reads to distinct addresses from reset -> ack order core0,1,2,3,0, each ack 4 cycles apart.
- Broadcast: cores 0,2,3 read 0x44 (data 0x99), core1 reads 0x45 -> first ack=4'b1101 with all three rdata=0x99, next ack=4'b0010; with BCAST_EN=0 -> four separate acks.
- Write not merged: core0 writes 0x44, core3 reads 0x44, rr_ptr=0 -> core0 write acked alone, then core3 read returns the new value.
- Hold and reset: ext_hold=1 with pending requests -> busy=0, no RAM activity for 10 cycles; release -> grant next cycle. rst asserted in WAIT -> no ack, all outputs 0 next cycle. RD_LAT=3 read -> ack at T+5.
